ieeedrv_sd_arb: RTL and testbench

IEEEDRV_SD_ARB -- requirements
Module: ieeedrv_sd_arb

---
 rtl/ieeedrv_sd_arb.sv | 164 ++++++++++++++++
 tb/tb_ieeedrv_sd_arb.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieeedrv_sd_arb.sv
// ieeedrv_sd_arb: round-robin arbiter sharing one host SD port
// among several sub-drives, with an issue-phase timeout.
module ieeedrv_sd_arb #(
  parameter int          SUBDRV  = 2,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF,
  localparam int         SW      = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [32*SUBDRV-1:0] req_lba,
  input  logic [6*SUBDRV-1:0]  req_blk_cnt,
  input  logic [SUBDRV-1:0]    req_rd,
  input  logic [SUBDRV-1:0]    req_wr,
  output logic [SUBDRV-1:0]    req_ack,
  output logic [SUBDRV-1:0]    req_err,
  output logic [31:0]          sd_lba,
  output logic [5:0]           sd_blk_cnt,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  output logic [SW-1:0]        sd_sel,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_sel;
  logic [SW-1:0] r_last;
  logic [31:0]   r_lba;
  logic [5:0]    r_blk;
  logic          r_rd;
  logic          r_wr;
  logic          r_ack;
  logic          r_err;
  logic [23:0]   r_wait;

  logic          w_found;
  logic [SW-1:0] w_gnt;
  logic [31:0]   w_lba;
  logic [5:0]    w_blk;
  logic          w_isw;
  logic          w_to;
  int            v_d;
  int            v_best;

  assign w_to = (r_wait + 24'd1) == TIMEOUT;

  // Round-robin pick: smallest distance after the last grant wins.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_lba   = '0;
    w_blk   = '0;
    w_isw   = 1'b0;
    v_best  = SUBDRV;
    v_d     = 0;
    for (int i = 0; i < SUBDRV; i++) begin
      v_d = (i + SUBDRV - 1 - int'(r_last)) % SUBDRV;
      if ((req_rd[i] || req_wr[i]) && v_d < v_best) begin
        v_best  = v_d;
        w_found = 1'b1;
        w_gnt   = SW'(i);
        w_lba   = req_lba[i*32 +: 32];
        w_blk   = req_blk_cnt[i*6 +: 6];
        w_isw   = req_wr[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: begin
        if (sd_ack)    w_next = S_XFER;
        else if (w_to) w_next = S_IDLE;
      end
      S_XFER:  if (!sd_ack) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Grant latch, strobes, wait counter and ack/err pulses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sel  <= '0;
      r_last <= SW'(SUBDRV - 1);
      r_lba  <= '0;
      r_blk  <= '0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_wait <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sel  <= w_gnt;
            r_lba  <= w_lba;
            r_blk  <= w_blk;
            r_wr   <= w_isw;
            r_rd   <= !w_isw;
            r_wait <= '0;
          end
        end
        S_ISSUE: begin
          if (sd_ack) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_ack <= 1'b1;
          end else if (w_to) begin
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            r_err  <= 1'b1;
            r_last <= r_sel;
          end else begin
            r_wait <= r_wait + 24'd1;
          end
        end
        S_XFER:  r_ack  <= sd_ack;
        S_DONE:  r_last <= r_sel;
        default: r_ack  <= 1'b0;
      endcase
    end
  end

  // Steer the single ack/err pulse to the granted sub-drive.
  always_comb begin
    req_ack = '0;
    req_err = '0;
    for (int i = 0; i < SUBDRV; i++) begin
      if (SW'(i) == r_sel) begin
        req_ack[i] = r_ack;
        req_err[i] = r_err;
      end
    end
  end

  assign sd_lba     = r_lba;
  assign sd_blk_cnt = r_blk;
  assign sd_rd      = r_rd;
  assign sd_wr      = r_wr;
  assign sd_sel     = r_sel;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// tb_ieeedrv_sd_arb: directed and randomized transactions
// against a request-level round-robin model.
module tb_ieeedrv_sd_arb;

  localparam int NS = 2;
  localparam int SW = 1;
  localparam int TO = 16;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [32*NS-1:0]  req_lba;
  logic [6*NS-1:0]   req_blk_cnt;
  logic [NS-1:0]     req_rd;
  logic [NS-1:0]     req_wr;
  logic [NS-1:0]     req_ack;
  logic [NS-1:0]     req_err;
  logic [31:0]       sd_lba;
  logic [5:0]        sd_blk_cnt;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [SW-1:0]     sd_sel;
  logic              busy;

  int          total = 0;
  int          bad   = 0;
  bit          pend_rd [NS];
  bit          pend_wr [NS];
  logic [31:0] mlba [NS];
  logic [5:0]  mcnt [NS];
  int          last;
  int          n;
  int          first;

  always #5 clk_sys = ~clk_sys;

  ieeedrv_sd_arb #(
    .SUBDRV (NS),
    .TIMEOUT(24'd16)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .req_lba    (req_lba),
    .req_blk_cnt(req_blk_cnt),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_ack    (req_ack),
    .req_err    (req_err),
    .sd_lba     (sd_lba),
    .sd_blk_cnt (sd_blk_cnt),
    .sd_rd      (sd_rd),
    .sd_wr      (sd_wr),
    .sd_ack     (sd_ack),
    .sd_sel     (sd_sel),
    .busy       (busy)
  );

  task automatic cyc();
    @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NS; i++) begin
      req_rd[i]             = pend_rd[i];
      req_wr[i]             = pend_wr[i];
      req_lba[i*32 +: 32]   = mlba[i];
      req_blk_cnt[i*6 +: 6] = mcnt[i];
    end
  endtask

  function automatic int rr_pick();
    int j;
    for (int k = 1; k <= NS; k++) begin
      j = (last + k) % NS;
      if (pend_rd[j] || pend_wr[j]) return j;
    end
    return -1;
  endfunction

  task automatic wait_strobe(output int cnt);
    cnt = 0;
    while (cnt < 40) begin
      cyc();
      cnt++;
      if (sd_rd || sd_wr) break;
    end
  endtask

  task automatic run_xfer(input int dly, input int len, input int exp_wait,
                          input bit scram, input bit cancel);
    int          g;
    int          w_n;
    bit          w;
    logic [31:0] elba;
    logic [5:0]  ecnt;
    logic [NS-1:0] oh;
    g = rr_pick();
    if (g < 0) return;
    w    = pend_wr[g];
    elba = mlba[g];
    ecnt = mcnt[g];
    oh   = '0;
    oh[g] = 1'b1;
    wait_strobe(w_n);
    chk("grant_wait", w_n, exp_wait);
    chk("strobe_dir", {sd_wr, sd_rd}, {w, !w});
    chk("sd_sel", sd_sel, g);
    chk("sd_lba", sd_lba, elba);
    chk("sd_blk", sd_blk_cnt, ecnt);
    chk("busy_issue", busy, 1);
    chk("err_quiet", req_err, 0);
    if (cancel) begin
      if (w) pend_wr[g] = 1'b0;
      else   pend_rd[g] = 1'b0;
      drive_req();
    end
    for (int k = 2; k <= dly; k++) begin
      cyc();
      chk("strobe_hold", {sd_wr, sd_rd}, {w, !w});
      chk("ack_issue", req_ack, 0);
    end
    sd_ack = 1'b1;
    for (int k = 1; k <= len; k++) begin
      cyc();
      chk("strobe_clr", {sd_wr, sd_rd}, 0);
      chk("req_ack", req_ack, oh);
      chk("err_xfer", req_err, 0);
      chk("lba_hold", sd_lba, elba);
      chk("sel_hold", sd_sel, g);
      if (k == 1 && !cancel) begin
        if (w) pend_wr[g] = 1'b0;
        else   pend_rd[g] = 1'b0;
      end
      if (scram) begin
        for (int i = 0; i < NS; i++) begin
          mlba[i] = $urandom;
          mcnt[i] = 6'($urandom);
        end
      end
      drive_req();
      if (k == len) sd_ack = 1'b0;
    end
    cyc();
    chk("ack_done", req_ack, 0);
    chk("busy_done", busy, 1);
    chk("lba_done", sd_lba, elba);
    last = g;
  endtask

  task automatic run_timeout();
    int g;
    int w_n;
    bit w;
    logic [NS-1:0] oh;
    g = rr_pick();
    if (g < 0) return;
    w  = pend_wr[g];
    oh = '0;
    oh[g] = 1'b1;
    wait_strobe(w_n);
    chk("to_wait", w_n, 1);
    chk("to_sel", sd_sel, g);
    chk("to_dir", {sd_wr, sd_rd}, {w, !w});
    for (int k = 2; k <= TO; k++) begin
      cyc();
      chk("to_hold", {sd_wr, sd_rd}, {w, !w});
      chk("to_noerr", req_err, 0);
    end
    cyc();
    chk("to_strobe", {sd_wr, sd_rd}, 0);
    chk("to_err", req_err, oh);
    chk("to_busy", busy, 0);
    chk("to_ack", req_ack, 0);
    last = g;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    sd_ack  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      pend_rd[i] = 1'b0;
      pend_wr[i] = 1'b0;
      mlba[i]    = '0;
      mcnt[i]    = '0;
    end
    drive_req();
    last = NS - 1;
    cyc();
    cyc();
    chk("reset_state",
        {sd_lba, sd_blk_cnt, sd_rd, sd_wr, req_ack, req_err, sd_sel, busy}, 0);
    reset_n = 1'b1;

    cyc();
    pend_rd[0] = 1'b1;
    mlba[0]    = 32'h1D;
    mcnt[0]    = 6'd28;
    drive_req();
    run_xfer(5, 10, 1, 0, 0);

    cyc();
    chk("idle_after_done", busy, 0);
    sd_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stray_ack", req_ack, 0);
      chk("stray_busy", busy, 0);
      chk("stray_lba", sd_lba, 32'h1D);
    end
    sd_ack = 1'b0;

    cyc();
    pend_rd[1] = 1'b1;
    pend_wr[1] = 1'b1;
    mlba[1]    = 32'h0000_1111;
    mcnt[1]    = 6'd3;
    drive_req();
    run_xfer(3, 2, 1, 0, 0);
    run_xfer(2, 2, 2, 0, 0);

    cyc();
    pend_rd[0] = 1'b1;
    mlba[0]    = 32'h0BAD_0000;
    drive_req();
    run_xfer(TO, 2, 1, 1, 0);

    cyc();
    pend_rd[0] = 1'b1;
    pend_rd[1] = 1'b1;
    drive_req();
    run_timeout();
    run_xfer(2, 2, 1, 0, 0);
    run_xfer(2, 2, 2, 0, 1);

    cyc();
    pend_rd[1] = 1'b1;
    mlba[1]    = 32'hCAFE_0001;
    mcnt[1]    = 6'd7;
    drive_req();
    wait_strobe(n);
    chk("rst_pre_sel", sd_sel, 1);
    sd_ack = 1'b1;
    cyc();
    cyc();
    chk("rst_pre_ack", req_ack, 2'b10);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async",
        {sd_lba, sd_blk_cnt, sd_rd, sd_wr, req_ack, req_err, sd_sel, busy}, 0);
    sd_ack     = 1'b0;
    mlba[1]    = 32'hCAFE_0002;
    pend_rd[0] = 1'b1;
    mlba[0]    = 32'hBEEF_0000;
    drive_req();
    cyc();
    chk("rst_hold",
        {sd_lba, sd_blk_cnt, sd_rd, sd_wr, req_ack, req_err, sd_sel, busy}, 0);
    reset_n = 1'b1;
    last    = NS - 1;
    run_xfer(2, 2, 1, 0, 0);
    run_xfer(2, 2, 2, 0, 0);

    for (int r = 0; r < 2; r++) begin
      cyc();
      pend_rd[0] = 1'b1;
      pend_rd[1] = 1'b1;
      drive_req();
      run_xfer(1, 1, 1, 0, 0);
      run_xfer(1, 1, 2, 0, 0);
    end

    for (int it = 0; it < 25; it++) begin
      cyc();
      chk("batch_idle", busy, 0);
      for (int i = 0; i < NS; i++) begin
        pend_rd[i] = 1'($urandom_range(0, 1));
        pend_wr[i] = 1'($urandom_range(0, 1));
        mlba[i]    = $urandom;
        mcnt[i]    = 6'($urandom);
      end
      if (rr_pick() < 0) pend_rd[$urandom_range(0, NS - 1)] = 1'b1;
      drive_req();
      first = 1;
      while (rr_pick() >= 0) begin
        run_xfer(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)),
                 (first != 0) ? 1 : 2, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
        first = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
